// File: rtl/sram_responder.sv
// sram_responder
// Device-side model of a 16-bit asynchronous-style SRAM. It sits on the SRAM
// pin interface that the MEM-stage controller drives, and it is used both in
// simulation and in on-chip loopback builds.
//
// Writes are byte-laned. Reads return through a fixed-latency pipeline.
// SRAM_DQ is driven only while the current strobes request a read.
//
// Optional build macro: SRAM_RESP_ADDR_CHECK_EN
//   When defined, an access with nonzero address bits above DEPTH_LOG2 is
//   dropped and sets protocol_err.
//   When undefined, those upper address bits alias into the array.
//
// Parameters:
//   DEPTH_LOG2    number of implemented word-address bits (2^DEPTH_LOG2 words)
//   READ_LATENCY  edges from read sample to data on SRAM_DQ, legal range 1..4
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous reset, active low
//   SRAM_ADDR     word address
//   SRAM_DQ       bidirectional data bus
//   SRAM_UB_N     upper byte lane enable, active low
//   SRAM_LB_N     lower byte lane enable, active low
//   SRAM_CE_N     chip enable, active low
//   SRAM_OE_N     output enable, active low
//   SRAM_WE_N     write enable, active low
//   wr_count      accepted write cycles, saturating
//   rd_count      accepted read samples, saturating
//   protocol_err  sticky illegal-strobe / bad-address flag
module sram_responder #(
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    input  logic        SRAM_WE_N,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        protocol_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LAST  = READ_LATENCY - 1;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_addr;
    logic                  addr_hi_nz;
    logic                  addr_ok;
    logic                  wr_sel;
    logic                  rd_sel;
    logic                  contention;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  err_set;
    logic                  drive_en;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_ub_n;
    logic [READ_LATENCY-1:0] pipe_lb_n;
    logic [15:0]             pipe_data [READ_LATENCY];

    assign word_addr  = SRAM_ADDR[DEPTH_LOG2-1:0];
    // A shift is used instead of a part-select so that DEPTH_LOG2 == 18 stays legal.
    assign addr_hi_nz = |(SRAM_ADDR >> DEPTH_LOG2);

`ifdef SRAM_RESP_ADDR_CHECK_EN
    assign addr_ok = !addr_hi_nz;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = addr_hi_nz;
    assign addr_ok        = 1'b1;
`endif

    // Contention (OE_N and WE_N both low) is still treated as a write.
    assign wr_sel     = !SRAM_CE_N && !SRAM_WE_N;
    assign rd_sel     = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
    assign contention = !SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N;
    assign wr_acc     = reset && wr_sel && addr_ok;
    assign rd_acc     = reset && rd_sel && addr_ok;
    assign err_set    = contention || ((wr_sel || rd_sel) && !addr_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_vld     <= '0;
            wr_count     <= 16'd0;
            rd_count     <= 16'd0;
            protocol_err <= 1'b0;
        end else begin
            // A stage holds valid data only if its input this edge was a read sample.
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            if (wr_acc && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rd_acc && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // The array and the pipeline payload are never reset; validity lives in pipe_vld.
    // The read takes the pre-edge array value, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (!SRAM_UB_N) mem[word_addr][15:8] <= SRAM_DQ[15:8];
            if (!SRAM_LB_N) mem[word_addr][7:0]  <= SRAM_DQ[7:0];
        end
        if (rd_acc) begin
            pipe_data[0] <= mem[word_addr];
            pipe_ub_n[0] <= SRAM_UB_N;
            pipe_lb_n[0] <= SRAM_LB_N;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_ub_n[i] <= pipe_ub_n[i-1];
            pipe_lb_n[i] <= pipe_lb_n[i-1];
        end
    end

    // Drive SRAM_DQ only while the present strobes request a read, so that the
    // responder never fights the controller during a write.
    assign drive_en = pipe_vld[LAST] && rd_sel;

    assign SRAM_DQ[15:8] = (drive_en && !pipe_ub_n[LAST]) ? pipe_data[LAST][15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drive_en && !pipe_lb_n[LAST]) ? pipe_data[LAST][7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder. It uses two instances: one with latency 1 for the
// functional checks and one with latency 3 for the pipeline and reset-flush checks.
// Both data buses are pulled up, so a released lane reads as 8'hFF. Read data in the
// stimulus never uses 8'hFF in a lane that is expected to be driven.
module tb_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
        else n_pass++;
    endtask

    // ---------------- latency-1 instance ----------------
    logic        rst1;
    logic [17:0] addr1;
    logic        ce1, we1, oe1, ub1, lb1, drv1;
    logic [15:0] wd1;
    wire  [15:0] dq1;
    logic [15:0] wc1, rc1;
    logic        err1;

    assign dq1 = drv1 ? wd1 : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pu1
        pullup (dq1[g]);
    end

    sram_responder #(.DEPTH_LOG2(12), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst1), .SRAM_ADDR(addr1), .SRAM_DQ(dq1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1),
        .SRAM_WE_N(we1), .wr_count(wc1), .rd_count(rc1), .protocol_err(err1)
    );

    // ---------------- latency-3 instance ----------------
    logic        rst3;
    logic [17:0] addr3;
    logic        ce3, we3, oe3, drv3;
    logic [15:0] wd3;
    wire  [15:0] dq3;
    logic [15:0] wc3, rc3;
    logic        err3;

    assign dq3 = drv3 ? wd3 : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pu3
        pullup (dq3[g]);
    end

    sram_responder #(.DEPTH_LOG2(12), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(rst3), .SRAM_ADDR(addr3), .SRAM_DQ(dq3),
        .SRAM_UB_N(1'b0), .SRAM_LB_N(1'b0), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3),
        .SRAM_WE_N(we3), .wr_count(wc3), .rd_count(rc3), .protocol_err(err3)
    );

    // ---------------- reference model (latency-1 instance) ----------------
    logic [15:0] m1 [4096];
    logic [15:0] m_wc = 16'd0;
    logic [15:0] m_rc = 16'd0;
    logic        m_err = 1'b0;
    logic [15:0] q1 [$];
    logic [15:0] q3 [$];

    // Called at a falling edge. It applies one cycle of strobes, lets the rising
    // edge happen, and then checks the outputs at the next falling edge.
    task automatic cyc1(input logic ce, input logic we, input logic oe, input logic ub,
                        input logic lb, input logic [17:0] a, input logic [15:0] d);
        logic        ok;
        logic        rd;
        logic [15:0] w;
        ce1 = ce; we1 = we; oe1 = oe; ub1 = ub; lb1 = lb; addr1 = a; wd1 = d;
        drv1 = !we;
        ok = 1'b1;
`ifdef SRAM_RESP_ADDR_CHECK_EN
        ok = (a[17:12] == 6'd0);
`endif
        if (!ce && !we && !oe) m_err = 1'b1;
        if (!ce && (!we || !oe) && !ok) m_err = 1'b1;
        rd = !ce && we && !oe && ok;
        if (rd) begin
            w = m1[a[11:0]];
            q1.push_back({ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]});
            if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
        end
        if (!ce && !we && ok) begin
            if (!ub) m1[a[11:0]][15:8] = d[15:8];
            if (!lb) m1[a[11:0]][7:0]  = d[7:0];
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        if (rd) check("rd_data", dq1, q1.pop_front());
        else if (we) check("dq_released", dq1, 16'hFFFF);
        check("wr_count", wc1, m_wc);
        check("rd_count", rc1, m_rc);
        check("protocol_err", {15'd0, err1}, {15'd0, m_err});
    endtask

    task automatic wr1(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        cyc1(1'b0, 1'b0, 1'b1, ub, lb, a, d);
    endtask

    task automatic rd1(input logic [17:0] a, input logic ub, input logic lb);
        cyc1(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0000);
    endtask

    task automatic reset1();
        rst1 = 1'b0;
        ce1 = 1'b1; we1 = 1'b1; oe1 = 1'b1; drv1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_count", wc1, 16'd0);
        check("rst_rd_count", rc1, 16'd0);
        check("rst_protocol_err", {15'd0, err1}, 16'd0);
        check("rst_dq", dq1, 16'hFFFF);
        rst1 = 1'b1;
        m_wc = 16'd0; m_rc = 16'd0; m_err = 1'b0;
        q1.delete();
    endtask

    task automatic cyc3(input logic ce, input logic we, input logic oe,
                        input logic [17:0] a, input logic [15:0] d);
        ce3 = ce; we3 = we; oe3 = oe; addr3 = a; wd3 = d; drv3 = !we;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        rst1 = 1'b0; ce1 = 1'b1; we1 = 1'b1; oe1 = 1'b1; ub1 = 1'b0; lb1 = 1'b0;
        addr1 = '0; wd1 = '0; drv1 = 1'b0;
        rst3 = 1'b0; ce3 = 1'b1; we3 = 1'b1; oe3 = 1'b1; addr3 = '0; wd3 = '0; drv3 = 1'b0;
        @(negedge clk);
        reset1();

        // Basic write then read
        wr1(18'd5, 16'hA55A, 1'b0, 1'b0);
        rd1(18'd5, 1'b0, 1'b0);

        // Lane-masked overwrite
        wr1(18'd7, 16'h1234, 1'b0, 1'b0);
        wr1(18'd7, 16'hFFEE, 1'b1, 1'b0);
        rd1(18'd7, 1'b0, 1'b0);

        // Partial-lane read
        wr1(18'd9, 16'hBE3C, 1'b0, 1'b0);
        rd1(18'd9, 1'b0, 1'b1);
        rd1(18'd9, 1'b1, 1'b0);

        // Write with both lanes masked still counts
        wr1(18'd9, 16'h0000, 1'b1, 1'b1);
        rd1(18'd9, 1'b0, 1'b0);

        // Back-to-back writes and reads
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom) & 16'h7E7E;
            wr1(18'(20 + i), v, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) rd1(18'(20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) rd1(18'(20 + i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Idle cycle
        cyc1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd5, 16'h0000);

        // Upper address bits: these alias by default, or are rejected when checked
        rd1(18'h01005, 1'b0, 1'b0);
        wr1(18'h20000, 16'h5A5A, 1'b0, 1'b0);
        wr1(18'd0, 16'h0102, 1'b0, 1'b0);
        rd1(18'd0, 1'b0, 1'b0);

        // Bus contention sets a sticky error and is treated as a write
        cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd11, 16'h4321);
        cyc1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 16'h0000);
        rd1(18'd11, 1'b0, 1'b0);

        // Reset with nonzero counters
        reset1();
        rd1(18'd5, 1'b0, 1'b0);

        // Latency-3 pipeline with a reset in mid-flight
        cyc3(1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);
        rst3 = 1'b1;
        cyc3(1'b0, 1'b0, 1'b1, 18'd0, 16'h0011);
        cyc3(1'b0, 1'b0, 1'b1, 18'd1, 16'h0022);
        cyc3(1'b0, 1'b0, 1'b1, 18'd2, 16'h0033);
        check("l3_wr_count", wc3, 16'd3);
        cyc3(1'b0, 1'b1, 1'b0, 18'd0, 16'h0000);
        q3.push_back(16'h0011);
        check("l3_edge1", dq3, 16'hFFFF);
        cyc3(1'b0, 1'b1, 1'b0, 18'd1, 16'h0000);
        q3.push_back(16'h0022);
        check("l3_edge2", dq3, 16'hFFFF);
        cyc3(1'b0, 1'b1, 1'b0, 18'd2, 16'h0000);
        q3.push_back(16'h0033);
        check("l3_edge3", dq3, q3.pop_front());
        cyc3(1'b0, 1'b1, 1'b0, 18'd3, 16'h0000);
        check("l3_edge4", dq3, q3.pop_front());
        rst3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc3(1'b0, 1'b1, 1'b0, 18'd2, 16'h0000);
            check("l3_flush", dq3, 16'hFFFF);
        end
        q3.delete();
        check("l3_rst_rd_count", rc3, 16'd0);
        check("l3_rst_wr_count", wc3, 16'd0);
        check("l3_rst_err", {15'd0, err3}, 16'd0);
        rst3 = 1'b1;
        cyc3(1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
